// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC result packer: FSM states, packet framing and
// the byte-select helper used by the serialiser.
package cordic_pkg;

    localparam int unsigned PktLen     = 5;
    localparam int unsigned ExtW       = 16;
    localparam logic [7:0]  DefaultHdr = 8'hA5;

    // One idle state plus one state per packet byte.
    typedef enum logic [$clog2(PktLen + 1)-1:0] {
        StIdle,
        StHdr,
        StXh,
        StXl,
        StYh,
        StYl
    } state_e;

    function automatic logic [7:0] pkt_byte(input state_e st, input logic [7:0] hdr,
                                            input logic [ExtW-1:0] x,
                                            input logic [ExtW-1:0] y);
        logic [7:0] b;
        unique case (st)
            StHdr:   b = hdr;
            StXh:    b = x[15:8];
            StXl:    b = x[7:0];
            StYh:    b = y[15:8];
            StYl:    b = y[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cordic_sample_fifo.sv
// Synchronous FIFO for captured (x, y) result pairs, using extra-MSB pointers so that full and
// empty are distinguishable across wrap-around.
module cordic_sample_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // The caller only pushes into a full FIFO when it pops in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/cordic_result_packer.sv
// Captures CORDIC (x, y) results into a FIFO and serialises each as a 5-byte framed packet
// onto a byte-wide valid/ready UART TX interface, counting samples dropped on overflow.
module cordic_result_packer
    import cordic_pkg::*;
#(
    parameter int unsigned OW    = 10,
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  HDR   = DefaultHdr
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic          i_valid,
    input  logic [OW-1:0] i_xcord,
    input  logic [OW-1:0] i_ycord,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic          o_busy,
    output logic          o_overflow,
    output logic [7:0]    o_drop_cnt
);

    localparam int unsigned W = 2 * OW;

    logic         offer, push, pop, drop, full, empty;
    logic [W-1:0] head;

    assign offer = i_ce && i_valid;
    assign push  = offer && (!full || pop);
    assign drop  = offer && full && !pop;

    cordic_sample_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({i_xcord, i_ycord}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    state_e          state_q, state_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            overflow_q;
    logic [7:0]      drop_cnt_q;
    logic signed [OW-1:0] x_d, y_d;
    logic [ExtW-1:0] x16_d, y16_d;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shadow_d = head;
                    state_d  = StHdr;
                end
            end
            StHdr: if (i_tx_ready) state_d = StXh;
            StXh:  if (i_tx_ready) state_d = StXl;
            StXl:  if (i_tx_ready) state_d = StYh;
            StYh:  if (i_tx_ready) state_d = StYl;
            StYl: begin
                if (i_tx_ready) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        shadow_d = head;
                        state_d  = StHdr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output byte is precomputed from the next state so data and valid leave flops directly.
    assign x_d        = shadow_d[W-1:OW];
    assign y_d        = shadow_d[OW-1:0];
    assign x16_d      = ExtW'(x_d);
    assign y16_d      = ExtW'(y_d);
    assign tx_data_d  = pkt_byte(state_d, HDR, x16_d, y16_d);
    assign tx_valid_d = (state_d != StIdle);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            shadow_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'h01;
            end
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = !empty || (state_q != StIdle);
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_cordic_result_packer.sv
// Scoreboard bench for cordic_result_packer: expected packet bytes are queued when samples are
// driven and compared as each byte is handed to the UART side.
module tb_cordic_result_packer;

    localparam int unsigned OW    = 10;
    localparam int unsigned DEPTH = 4;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_ce = 1'b0, i_valid = 1'b0, i_tx_ready = 1'b0;
    logic [OW-1:0] i_xcord = '0, i_ycord = '0;
    logic [7:0]    o_tx_data, o_drop_cnt;
    logic          o_tx_valid, o_busy, o_overflow;

    cordic_result_packer #(
        .OW    (OW),
        .DEPTH (DEPTH),
        .HDR   (8'hA5)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_ce       (i_ce),
        .i_valid    (i_valid),
        .i_xcord    (i_xcord),
        .i_ycord    (i_ycord),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int         total = 0, bad = 0, nbytes = 0;
    logic [7:0] sb[$];
    int         cyc = 0, first_v = -1, last_v = -1;
    logic       prev_v = 1'b0, busy_fall = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int x, input int y);
        logic [15:0] xv, yv;
        xv = 16'(x);
        yv = 16'(y);
        sb.push_back(8'hA5);
        sb.push_back(xv[15:8]);
        sb.push_back(xv[7:0]);
        sb.push_back(yv[15:8]);
        sb.push_back(yv[7:0]);
    endtask

    // Called just after a rising edge; the sample is captured at the next edge.
    task automatic send(input int x, input int y, input bit kept);
        if (kept) push_pkt(x, y);
        i_ce    = 1'b1;
        i_valid = 1'b1;
        i_xcord = OW'(x);
        i_ycord = OW'(y);
        @(posedge i_clk);
        #1;
        i_ce    = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((o_busy || sb.size() != 0) && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check_eq({tag, "_busy_low"}, 32'(o_busy), 0);
        check_eq({tag, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_tx_valid && n < 20) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check_eq({tag, "_valid"}, 32'(o_tx_valid), 1);
    endtask

    always @(negedge i_clk) begin
        if (i_reset_n && o_tx_valid && i_tx_ready) begin
            nbytes++;
            check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) check_eq("byte", 32'(o_tx_data), 32'(sb.pop_front()));
        end
    end

    always @(negedge i_clk) begin
        cyc++;
        if (o_tx_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (prev_v && !o_tx_valid) busy_fall = o_busy;
        prev_v = o_tx_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset_n = 1'b1;
        #1 i_reset_n = 1'b0;
        #20;
        check_eq("rst_valid", 32'(o_tx_valid), 0);
        check_eq("rst_data", 32'(o_tx_data), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_ovf", 32'(o_overflow), 0);
        check_eq("rst_drop", 32'(o_drop_cnt), 0);
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic packet and capture-to-valid latency.
        i_tx_ready = 1'b1;
        nbytes = 0;
        send(511, -512, 1'b1);
        check_eq("lat_pre_valid", 32'(o_tx_valid), 0);
        @(posedge i_clk);
        #1;
        check_eq("lat_valid", 32'(o_tx_valid), 1);
        check_eq("lat_hdr", 32'(o_tx_data), 'hA5);
        drain("basic");
        check_eq("basic_nbytes", 32'(nbytes), 5);

        // Backpressure while XL is presented.
        i_tx_ready = 1'b0;
        nbytes = 0;
        send(-3, 100, 1'b1);
        wait_valid("bp");
        i_tx_ready = 1'b1;
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        i_tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_eq("bp_hold_data", 32'(o_tx_data), 'hFD);
            check_eq("bp_hold_valid", 32'(o_tx_valid), 1);
            @(posedge i_clk);
            #1;
        end
        i_tx_ready = 1'b1;
        drain("bp");
        check_eq("bp_nbytes", 32'(nbytes), 5);

        // Enable gating: i_valid held, i_ce 1,0,1.
        nbytes = 0;
        push_pkt(1, 2);
        push_pkt(5, 6);
        i_valid = 1'b1;
        i_ce = 1'b1; i_xcord = OW'(1); i_ycord = OW'(2);
        @(posedge i_clk);
        #1;
        i_ce = 1'b0; i_xcord = OW'(3); i_ycord = OW'(4);
        @(posedge i_clk);
        #1;
        i_ce = 1'b1; i_xcord = OW'(5); i_ycord = OW'(6);
        @(posedge i_clk);
        #1;
        i_ce = 1'b0;
        i_valid = 1'b0;
        drain("gate");
        check_eq("gate_nbytes", 32'(nbytes), 10);

        // Back-to-back packets with ready held high.
        nbytes = 0;
        first_v = -1;
        last_v = -1;
        busy_fall = 1'b1;
        send(7, -7, 1'b1);
        send(-100, 200, 1'b1);
        send(255, -256, 1'b1);
        drain("b2b");
        check_eq("b2b_nbytes", 32'(nbytes), 15);
        check_eq("b2b_span", 32'(last_v - first_v + 1), 15);
        check_eq("b2b_busy_fall", 32'(busy_fall), 0);

        // Overflow: six samples with ready low, one must be dropped.
        i_tx_ready = 1'b0;
        nbytes = 0;
        for (int i = 0; i < 6; i++) send(10 * i + 1, -(10 * i + 2), i < 5);
        check_eq("ovf_drop_cnt", 32'(o_drop_cnt), 1);
        check_eq("ovf_flag", 32'(o_overflow), 1);
        i_tx_ready = 1'b1;
        drain("ovf");
        check_eq("ovf_nbytes", 32'(nbytes), 25);
        check_eq("ovf_drop_hold", 32'(o_drop_cnt), 1);

        // Reset asserted while XH is presented.
        send(-33, 33, 1'b1);
        wait_valid("mr");
        @(posedge i_clk);
        #1;
        check_eq("mr_xh", 32'(o_tx_data), 'hFF);
        i_reset_n = 1'b0;
        #1;
        check_eq("mr_valid", 32'(o_tx_valid), 0);
        check_eq("mr_data", 32'(o_tx_data), 0);
        check_eq("mr_busy", 32'(o_busy), 0);
        check_eq("mr_ovf", 32'(o_overflow), 0);
        check_eq("mr_drop", 32'(o_drop_cnt), 0);
        sb.delete();
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        nbytes = 0;
        send(5, 5, 1'b1);
        @(posedge i_clk);
        #1;
        check_eq("mr_hdr", 32'(o_tx_data), 'hA5);
        drain("mr");
        check_eq("mr_nbytes", 32'(nbytes), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_result_packer.md
# cordic_result_packer

Downstream stage of the CORDIC rotation engine. Captures each valid rotated (x, y) result pair, buffers it in a small FIFO, and serialises it as a fixed 5-byte framed packet onto the byte-wide valid/ready interface of the UART transmitter. It decouples the CORDIC pipeline throughput from the UART byte rate. It reports dropped samples when the buffer overflows.

## Interface
Parameters:
- OW, 10: width of the signed CORDIC result words; legal range 2..16.
- DEPTH, 4: FIFO depth in result pairs; must be a power of 2, at least 2.
- HDR, 8'hA5: packet header byte.

Ports:
- i_clk, in, 1: single clock.
- i_reset_n, in, 1: asynchronous, active-low reset.
- i_ce, in, 1: CORDIC clock enable. Samples are qualified by this signal.
- i_valid, in, 1: CORDIC aux output marking a valid result.
- i_xcord, in, OW: signed rotated x result.
- i_ycord, in, OW: signed rotated y result.
- o_tx_data, out, 8: byte to the UART TX.
- o_tx_valid, out, 1: o_tx_data is valid.
- i_tx_ready, in, 1: UART TX accepts the byte this cycle.
- o_busy, out, 1: FIFO is non-empty or a packet is in flight.
- o_overflow, out, 1: sticky flag, set on the first dropped sample.
- o_drop_cnt, out, 8: count of dropped samples; saturates at 255.

## Operation
- Capture: a sample is offered when i_ce && i_valid is high at a rising edge. The captured word is {i_xcord, i_ycord}, 2*OW bits.
- Push rule: the sample is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped.
  - On a drop, o_overflow is set and o_drop_cnt is incremented (saturating at 255).
  - The FIFO contents are never overwritten.
- Packet format, 5 bytes: HDR, X[15:8], X[7:0], Y[15:8], Y[7:0]. X and Y are sign-extended from OW to 16 bits.
  - Example: OW=10, x = -1 is sent as FF FF.
- FSM states: IDLE, HDR, XH, XL, YH, YL.
  - IDLE: if the FIFO is non-empty, pop the head into a shadow register and go to HDR. Otherwise stay in IDLE.
  - HDR, XH, XL, YH: o_tx_valid=1 with the state's byte. On i_tx_ready, advance to the next state. Otherwise hold both data and state.
  - YL: on i_tx_ready, if the FIFO is non-empty, pop and go to HDR (back-to-back packets, no IDLE gap). Otherwise go to IDLE.
- Handshake: once o_tx_valid is asserted, it stays high and o_tx_data stays stable until i_tx_ready is sampled high. A byte is transferred on any edge where o_tx_valid && i_tx_ready.
- o_busy = FIFO non-empty OR state != IDLE.
- o_overflow and o_drop_cnt clear only on reset.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from i_tx_ready to o_tx_valid or o_tx_data.
- Reset values: state=IDLE, FIFO empty, o_tx_data=8'h00, o_tx_valid=0, o_busy=0, o_overflow=0, o_drop_cnt=0.
- Latency with the FSM idle and the FIFO empty:
  - Sample captured at edge t0.
  - FSM pops at edge t0+1.
  - o_tx_valid=1 with HDR is visible after edge t0+1.
- Throughput with i_tx_ready held high: one byte per clock, 5 clocks per packet, no gap between packets.
- Reset asserted mid-packet: the packet is abandoned immediately and asynchronously, and the FIFO is flushed. After release, the block starts cleanly in IDLE.
- The FIFO pointers are log2(DEPTH)+1 bits wide. Full is signalled when the MSBs differ and the lower bits are equal. Pointer wrap-around must be handled.
- Simultaneous push and pop when full: both happen and the count stays DEPTH.
- Simultaneous push and pop when empty does not occur, because a pop requires a non-empty FIFO in the prior cycle.

## Structure
- Package cordic_pkg holds:
  - the state enum (IDLE, HDR, XH, XL, YH, YL);
  - the default HDR value;
  - the packet length constant, 5;
  - the sign-extension width, 16.
- Sub-module cordic_sample_fifo: synchronous FIFO with parameters WIDTH=2*OW and DEPTH. It provides push/pop/full/empty and uses the same clock and asynchronous active-low reset.
- The top level contains the capture qualifier, the drop counter, the shadow register and the FSM/byte mux.

## Test plan
- Basic packet: OW=10, x=10'sd511, y=-10'sd512, i_tx_ready=1 → bytes A5 01 FF FE 00 on 5 consecutive cycles; o_tx_valid rises one edge after capture.
- Backpressure: i_tx_ready low for 7 cycles during XL → o_tx_data holds the XL byte and o_tx_valid stays 1; no byte is lost or duplicated.
- Enable gating: i_valid=1 held with i_ce toggling 1,0,1 → exactly 2 samples are captured.
- Overflow: i_tx_ready=0, 6 qualified samples, DEPTH=4 → 5 samples are kept (4 in the FIFO plus 1 in the shadow register), o_drop_cnt=1, o_overflow=1; the kept samples are emitted in order after i_tx_ready rises.
- Back-to-back: 3 samples, ready always high → 15 contiguous bytes with no IDLE cycle between packets; o_busy falls one cycle after the final YL transfer.
- Mid-packet reset: assert i_reset_n=0 during XH → all outputs go to their reset values asynchronously; after release the next sample produces a clean A5 header.
